// File: rtl/memory_pkg.sv
// +----------------------------------------------------------------------------+
// | memory_pkg                                                                 |
// | Shared types, control-FSM state codes and op decode for memory_responder.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package memory_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] S_NONE            = 5'h00;
    localparam logic [STATE_W-1:0] S_FETCH_ADDRESS_1 = 5'h03;
    localparam logic [STATE_W-1:0] S_FETCH_MEMORY    = 5'h07;
    localparam logic [STATE_W-1:0] S_TEMP_FETCH      = 5'h0B;
    localparam logic [STATE_W-1:0] S_STORE_MEMORY    = 5'h0E;
    localparam logic [STATE_W-1:0] S_TEMP_STORE      = 5'h12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_fsm_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [STATE_W-1:0] state);
        mem_op_t op;
        op = OP_NONE;
        case (state)
            S_FETCH_MEMORY, S_TEMP_FETCH, S_FETCH_ADDRESS_1: op = OP_READ;
            S_STORE_MEMORY, S_TEMP_STORE:                    op = OP_WRITE;
            default:                                         op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_responder_if.sv
// +----------------------------------------------------------------------------+
// | memory_responder_if                                                        |
// | CPU address/data bus between the control FSM and the memory responder.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface memory_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] address_bus;
    logic [4:0]            state;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  mem_ready;
    logic                  bus_error;

    modport master (
        output address_bus, state, data_in,
        input  data_out, mem_ready, bus_error
    );

    modport slave (
        input  address_bus, state, data_in,
        output data_out, mem_ready, bus_error
    );
endinterface

`default_nettype wire

// File: rtl/memory_array.sv
// +----------------------------------------------------------------------------+
// | memory_array                                                               |
// | Single-port synchronous byte RAM, registered read (1-cycle latency).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module memory_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clock,
    input  wire logic                  we_i,
    input  wire logic [DEPTH_LOG2-1:0] addr_i,
    input  wire logic [DATA_WIDTH-1:0] wdata_i,
    output logic      [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/memory_responder.sv
// +----------------------------------------------------------------------------+
// | memory_responder                                                           |
// | Memory-side bus responder: latches a request, waits WAIT_STATES cycles,    |
// | accesses the byte RAM and pulses mem_ready. Option: ROM_PROTECT_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module memory_responder
    import memory_pkg::*;
#(
    parameter int                  ADDR_WIDTH    = 16,
    parameter int                  DATA_WIDTH    = 8,
    parameter int                  DEPTH_LOG2    = 10,
    parameter int                  WAIT_STATES   = 1,
    parameter logic [ADDR_WIDTH-1:0] PROTECT_LIMIT = 16'h0100
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    memory_responder_if.slave bus
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    mem_fsm_t              fsm_q, fsm_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    mem_op_t               op_q, op_d;
    logic [4:0]            state_q, state_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;

    logic                  w_mapped;
    logic                  w_protected;
    logic                  w_fault;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    mem_op_t               w_op_in;

    generate
        if (DEPTH_LOG2 < ADDR_WIDTH) begin : g_map_partial
            assign w_mapped = (addr_q[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
        end else begin : g_map_full
            assign w_mapped = 1'b1;
        end
    endgenerate

`ifdef ROM_PROTECT_EN
    assign w_protected = (addr_q < PROTECT_LIMIT);
`else
    assign w_protected = 1'b0;
`endif

    assign w_op_in = decode_op(bus.state);
    assign w_fault = !w_mapped || ((op_q == OP_WRITE) && w_protected);

    always_comb begin
        fsm_d      = fsm_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        state_d    = state_q;
        armed_d    = armed_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        w_ram_we   = 1'b0;

        // A held request must change state code or address before it can fire again
        if (!armed_q && ((bus.state != state_q) || (bus.address_bus != addr_q))) begin
            armed_d = 1'b1;
        end

        case (fsm_q)
            IDLE: begin
                if (armed_q && (w_op_in != OP_NONE)) begin
                    addr_d     = bus.address_bus;
                    data_d     = bus.data_in;
                    op_d       = w_op_in;
                    state_d    = bus.state;
                    wait_cnt_d = 4'd0;
                    fsm_d      = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    fsm_d = ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ACCESS: begin
                armed_d  = 1'b0;
                ready_d  = 1'b1;
                error_d  = w_fault;
                w_ram_we = (op_q == OP_WRITE) && !w_fault;
                if ((op_q == OP_READ) && !w_mapped) begin
                    data_out_d = {DATA_WIDTH{1'b1}};
                end
                fsm_d = DONE;
            end
            DONE: begin
                if ((op_q == OP_READ) && w_mapped) begin
                    data_out_d = w_ram_rdata;
                end
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fsm_q      <= IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            data_q     <= '0;
            op_q       <= OP_NONE;
            state_q    <= '0;
            armed_q    <= 1'b1;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_q       <= op_d;
            state_q    <= state_d;
            armed_q    <= armed_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    memory_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock   (clock),
        .we_i    (w_ram_we),
        .addr_i  (addr_q[DEPTH_LOG2-1:0]),
        .wdata_i (data_q),
        .rdata_o (w_ram_rdata)
    );

    // RAM data arrives one cycle after ACCESS, so mapped reads bypass the holding register in DONE
    assign bus.data_out  = ((fsm_q == DONE) && (op_q == OP_READ) && w_mapped) ? w_ram_rdata
                                                                               : data_out_q;
    assign bus.mem_ready = ready_q;
    assign bus.bus_error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// +----------------------------------------------------------------------------+
// | tb_memory_responder                                                        |
// | Directed bench for memory_responder with a scoreboard of expected replies. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_memory_responder;
    import memory_pkg::*;

    localparam int WS = 1;
`ifdef ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        bit         chk;
        logic [7:0] data;
        bit         err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   passed;
    int   failed;
    int   total;
    int   pulses;
    exp_t sb[$];
    logic [7:0] model [int];

    memory_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    memory_responder #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (8),
        .DEPTH_LOG2    (10),
        .WAIT_STATES   (WS),
        .PROTECT_LIMIT (16'h0100)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent expectation: RAM model of committed writes, 1 KiB mapped, ROM below 0x100
    function automatic exp_t make_exp(input logic [4:0] st, input logic [15:0] a,
                                      input logic [7:0] d);
        exp_t e;
        bit   wr;
        wr     = (st == S_STORE_MEMORY) || (st == S_TEMP_STORE);
        e.err  = (a >= 16'h0400) || (wr && PROT && (a < 16'h0100));
        e.chk  = 1'b0;
        e.data = 8'h00;
        if (wr) begin
            if (!e.err) model[int'(a)] = d;
        end else if (a >= 16'h0400) begin
            e.chk  = 1'b1;
            e.data = 8'hFF;
        end else if (model.exists(int'(a))) begin
            e.chk  = 1'b1;
            e.data = model[int'(a)];
        end
        return e;
    endfunction

    task automatic run_op(input logic [4:0] st, input logic [15:0] a, input logic [7:0] d,
                          input string tag);
        int lat;
        @(negedge clk);
        bus.state       = st;
        bus.address_bus = a;
        bus.data_in     = d;
        sb.push_back(make_exp(st, a, d));
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, 2 + WS);
        @(negedge clk);
        check({tag, " pulse width"}, {31'd0, bus.mem_ready}, 32'd0);
        bus.state = S_NONE;
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.mem_ready) begin
            exp_t e;
            total++;
            assert (sb.size() != 0) passed++;
            else begin
                failed++;
                $error("FAIL unexpected_ready: observed %0d queued expected >0", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("bus_error", {31'd0, bus.bus_error}, {31'd0, e.err});
                if (e.chk) check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
            end
        end
    end

    initial begin
        passed          = 0;
        failed          = 0;
        total           = 0;
        reset_n         = 1'b0;
        bus.state       = S_NONE;
        bus.address_bus = 16'h0000;
        bus.data_in     = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst data_out", {24'd0, bus.data_out}, 32'h00);
        check("rst mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst bus_error", {31'd0, bus.bus_error}, 32'd0);
        check("rst fsm", {30'd0, dut.fsm_q}, {30'd0, IDLE});
        reset_n = 1'b1;

        // Write then read back
        run_op(S_STORE_MEMORY, 16'h0123, 8'h5A, "wr123");
        run_op(S_FETCH_MEMORY, 16'h0123, 8'h00, "rd123");

        // Unmapped read, unmapped write at first unmapped address, last mapped byte
        run_op(S_TEMP_FETCH, 16'h8000, 8'h00, "rd8000");
        run_op(S_STORE_MEMORY, 16'h0400, 8'hC3, "wr0400");
        run_op(S_FETCH_MEMORY, 16'h0400, 8'h00, "rd0400");
        run_op(S_TEMP_STORE, 16'h03FF, 8'hE7, "wr03ff");
        run_op(S_FETCH_ADDRESS_1, 16'h03FF, 8'h00, "rd03ff");

        // Held request fires once; address change fires again
        run_op(S_STORE_MEMORY, 16'h0010, 8'h31, "wr0010");
        run_op(S_STORE_MEMORY, 16'h0011, 8'h32, "wr0011");
        @(negedge clk);
        bus.state       = S_FETCH_MEMORY;
        bus.address_bus = 16'h0010;
        sb.push_back(make_exp(S_FETCH_MEMORY, 16'h0010, 8'h00));
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_ready) pulses++;
        end
        check("held pulses", pulses, 1);
        bus.address_bus = 16'h0011;
        sb.push_back(make_exp(S_FETCH_MEMORY, 16'h0011, 8'h00));
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_ready) pulses++;
        end
        check("addr change pulses", pulses, 1);
        bus.state = S_NONE;

        // Reset during WAIT aborts a write
        run_op(S_STORE_MEMORY, 16'h0040, 8'h11, "wr0040");
        @(negedge clk);
        bus.state       = S_STORE_MEMORY;
        bus.address_bus = 16'h0040;
        bus.data_in     = 8'h77;
        @(negedge clk);
        check("abort in wait", {30'd0, dut.fsm_q}, {30'd0, WAIT});
        reset_n   = 1'b0;
        bus.state = S_NONE;
        pulses    = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_ready) pulses++;
        end
        check("abort pulses", pulses, 0);
        run_op(S_FETCH_MEMORY, 16'h0040, 8'h00, "rd0040");

        // Low-address write: dropped with error when protected, committed otherwise
        run_op(S_TEMP_STORE, 16'h0020, 8'hAA, "wr0020");
        run_op(S_FETCH_MEMORY, 16'h0020, 8'h00, "rd0020");

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
